// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and issues one outstanding word fetch at a time.
// It buffers {pc, inst} pairs for decode. A redirect restarts fetch and flushes stale work.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_r;
    logic [31:0]     fetch_pc_r;
    logic [31:0]     ent_pc_r   [DEPTH];
    logic [31:0]     ent_inst_r [DEPTH];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            req_valid_r;
    logic [31:0]     req_addr_r;
    logic            inst_valid_r;
    logic [31:0]     inst_r;
    logic [31:0]     pc_r;

    state_t          state_s;
    logic [31:0]     fetch_pc_s;
    logic [PW-1:0]   rd_ptr_s;
    logic [PW-1:0]   wr_ptr_s;
    logic [CW-1:0]   count_s;
    logic            handshake_s;
    logic            push_s;
    logic            pop_s;
    logic [31:0]     push_pc_s;
    logic            head_new_s;
    logic [31:0]     head_pc_s;
    logic [31:0]     head_inst_s;

    // Next-state for the fetch FSM, buffer pointers and the post-edge head entry.
    always_comb begin
        handshake_s = req_valid_r && imem_req_ready;
        pop_s       = inst_valid_r && inst_ready;
        push_s      = 1'b0;
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        // fetch_pc already advanced at the handshake, so the response belongs to pc-4
        push_pc_s   = fetch_pc_r - 32'd4;

        case (state_r)
            ST_REQ: begin
                if (handshake_s) begin
                    fetch_pc_s = fetch_pc_r + 32'd4;
                    state_s    = ST_WAIT;
                end else begin
                    state_s    = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    push_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: state_s = ST_REQ;
        endcase

        if (redirect_valid) begin
            fetch_pc_s = redirect_pc & 32'hFFFF_FFFC;
            push_s     = 1'b0;
            pop_s      = 1'b0;
            rd_ptr_s   = {PW{1'b0}};
            wr_ptr_s   = {PW{1'b0}};
            count_s    = {CW{1'b0}};
            case (state_r)
                ST_REQ:           state_s = handshake_s ? ST_DROP : ST_REQ;
                ST_WAIT, ST_DROP: state_s = imem_resp_valid ? ST_REQ : ST_DROP;
                default:          state_s = ST_REQ;
            endcase
        end else begin
            rd_ptr_s = rd_ptr_r + PW'(pop_s);
            wr_ptr_s = wr_ptr_r + PW'(push_s);
            count_s  = count_r + CW'(push_s) - CW'(pop_s);
        end

        // Pushing into a buffer that is empty after this edge's pop makes the new word the head
        head_new_s = push_s && (count_r == CW'(pop_s));
        if (head_new_s) begin
            head_pc_s   = push_pc_s;
            head_inst_s = imem_resp_data;
        end else begin
            head_pc_s   = ent_pc_r[rd_ptr_s];
            head_inst_s = ent_inst_r[rd_ptr_s];
        end
    end

    // State, buffer storage and registered outputs computed from next-state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_REQ;
            fetch_pc_r   <= RESET_PC;
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            req_valid_r  <= 1'b0;
            req_addr_r   <= 32'd0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            pc_r         <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_r[i]   <= 32'd0;
                ent_inst_r[i] <= 32'd0;
            end
        end else begin
            state_r      <= state_s;
            fetch_pc_r   <= fetch_pc_s;
            rd_ptr_r     <= rd_ptr_s;
            wr_ptr_r     <= wr_ptr_s;
            count_r      <= count_s;
            if (push_s) begin
                ent_pc_r[wr_ptr_r]   <= push_pc_s;
                ent_inst_r[wr_ptr_r] <= imem_resp_data;
            end
            req_valid_r  <= (state_s == ST_REQ) && (count_s < DEPTH_C);
            req_addr_r   <= fetch_pc_s;
            inst_valid_r <= (count_s != {CW{1'b0}});
            inst_r       <= (count_s != {CW{1'b0}}) ? head_inst_s : 32'd0;
            pc_r         <= (count_s != {CW{1'b0}}) ? head_pc_s : 32'd0;
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = req_addr_r;
    assign inst_valid     = inst_valid_r;
    assign inst           = inst_r;
    assign pc             = pc_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a behavioural 1-cycle memory plus a PC-sequence
// scoreboard on requests and decode pops, with targeted redirect/reset scenarios.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          pop_cnt = 0;
    int          base;
    int          n;
    bit          mem_auto;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic [31:0] req_log [$];
    int          pop_cyc [$];

    ifu_fetch #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .pc              (pc),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock: observe handshakes/pops before the edge, score them, model memory after it.
    task automatic tick();
        logic        hs, pp;
        logic [31:0] a, ppc, pin;
        hs  = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        pp  = inst_valid && inst_ready;
        ppc = pc;
        pin = inst;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            req_log.push_back(a);
            chk("req_addr", a, exp_req);
            exp_req = exp_req + 32'd4;
        end
        if (pp) begin
            pop_cyc.push_back(cyc);
            chk("pop_pc", ppc, exp_pc);
            chk("pop_inst", pin, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pop_cnt++;
        end
        if (mem_auto) begin
            imem_resp_valid = hs;
            imem_resp_data  = hs ? mem_word(a) : 32'd0;
        end
    endtask

    task automatic sync_req_with_head();
        int k;
        k = 0;
        while (!(imem_req_valid && inst_valid) && k < 10) begin
            tick();
            k++;
        end
        chk("sync_timeout", 32'(k < 10), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        mem_auto = 1'b1;
        exp_req = 32'h8000_0000;
        exp_pc  = 32'h8000_0000;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);

        // Streaming after release
        #2;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);
        repeat (8) tick();
        chk("stream_req0", req_log[0], 32'h8000_0000);
        chk("stream_req1", req_log[1], 32'h8000_0004);
        chk("stream_req2", req_log[2], 32'h8000_0008);
        chk("stream_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
        chk("stream_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);

        // Backpressure: buffer fills to two, then drains in order
        inst_ready = 1'b0;
        base = pop_cnt;
        repeat (10) tick();
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        chk("bp_inst_valid", 32'(inst_valid), 32'd1);
        chk("bp_no_pop", 32'(pop_cnt - base), 32'd0);
        mem_auto = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready = 1'b1;
        tick();
        chk("bp_req_rise", 32'(imem_req_valid), 32'd1);
        chk("bp_req_addr", imem_req_addr, exp_req);
        tick();
        tick();
        chk("bp_drained", 32'(pop_cnt - base), 32'd2);
        chk("bp_empty", 32'(inst_valid), 32'd0);

        // Redirect while waiting for a response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        exp_req = 32'h8000_0100;
        exp_pc  = 32'h8000_0100;
        chk("rw_inst_valid", 32'(inst_valid), 32'd0);
        chk("rw_drop_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("rw_drop_hold", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("rw_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rw_req_addr", imem_req_addr, 32'h8000_0100);
        chk("rw_no_stale", 32'(inst_valid), 32'd0);
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        base = pop_cnt;
        repeat (5) tick();
        chk("rw_pops", 32'(pop_cnt - base), 32'd2);

        // Redirect together with a pop and a request handshake
        inst_ready = 1'b0;
        sync_req_with_head();
        mem_auto = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        exp_req = 32'h8000_0200;
        exp_pc  = 32'h8000_0200;
        chk("rs_inst_valid", 32'(inst_valid), 32'd0);
        chk("rs_drop_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("rs_drop_hold", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("rs_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rs_req_addr", imem_req_addr, 32'h8000_0200);
        chk("rs_no_stale", 32'(inst_valid), 32'd0);

        // Redirect together with a push and a pop, to an unaligned target near the top
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h8000_0200);
        tick();
        imem_resp_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        chk("rp_head", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = mem_word(32'h8000_0204);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b0;
        exp_req = 32'hFFFF_FFFC;
        exp_pc  = 32'hFFFF_FFFC;
        chk("rp_inst_valid", 32'(inst_valid), 32'd0);
        chk("rp_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rp_req_addr", imem_req_addr, 32'hFFFF_FFFC);

        // Fetch wraps from the top of the address space to zero
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        n = req_log.size();
        repeat (6) tick();
        chk("wrap_nreq", 32'(req_log.size() >= n + 2), 32'd1);
        if (req_log.size() >= n + 2) begin
            chk("wrap_req0", req_log[n], 32'hFFFF_FFFC);
            chk("wrap_req1", req_log[n + 1], 32'h0000_0000);
        end

        // Asynchronous reset while a request is outstanding
        inst_ready = 1'b0;
        sync_req_with_head();
        mem_auto = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        chk("ar_req_valid", 32'(imem_req_valid), 32'd0);
        chk("ar_inst_valid", 32'(inst_valid), 32'd0);
        chk("ar_inst", inst, 32'd0);
        chk("ar_pc", pc, 32'd0);
        tick();
        #2;
        rst = 1'b1;
        exp_req = 32'h8000_0000;
        exp_pc  = 32'h8000_0000;
        mem_auto = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("ar_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("ar_restart_addr", imem_req_addr, 32'h8000_0000);
        base = pop_cnt;
        repeat (5) tick();
        chk("ar_pops", 32'(pop_cnt - base), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
